hazard_controller: RTL

Pipeline hazard and sequencing controller for the 5-stage core. It drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand forwarding selects. It handles load-use stalls, taken-branch flushes, and multi-cycle data-memory waits in M, with a bounded timeout and a stall-cycle performance counter.

---
 rtl/hazard_controller.sv | 71 +++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward control for the 5-stage core, with a bounded
// data-memory wait FSM and a performance counter of cycles spent stalling fetch.
module hazard_controller #(
  parameter int REGISTER_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REGISTER_WIDTH-1:0] rs1_d_i,
  input  logic [REGISTER_WIDTH-1:0] rs2_d_i,
  input  logic [REGISTER_WIDTH-1:0] rs1_e_i,
  input  logic [REGISTER_WIDTH-1:0] rs2_e_i,
  input  logic [REGISTER_WIDTH-1:0] rd_e_i,
  input  logic [REGISTER_WIDTH-1:0] rd_m_i,
  input  logic [REGISTER_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  input  logic [1:0]                result_src_e_i,
  input  logic                      pc_src_e_i,
  input  logic                      mem_req_m_i,
  input  logic                      mem_ready_i,
  output logic [1:0]                forward_a_e_o,
  output logic [1:0]                forward_b_e_o,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      stall_e_o,
  output logic                      stall_m_o,
  output logic                      flush_d_o,
  output logic                      flush_e_o,
  output logic                      flush_w_o,
  output logic                      mem_timeout_o,
  output logic [CNT_WIDTH-1:0]      stall_count_o
);
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic          w_abort, w_wait, w_lu, w_br, w_lu_stall;
  function automatic logic [1:0] fwd(input logic [REGISTER_WIDTH-1:0] rs);
    return (reg_write_m_i && rd_m_i != '0 && rd_m_i == rs) ? 2'b10 :
           (reg_write_w_i && rd_w_i != '0 && rd_w_i == rs) ? 2'b01 : 2'b00;
  endfunction
  assign w_abort = (r_state == WAIT) && mem_req_m_i && !mem_ready_i && r_cnt == TW'(MEM_TIMEOUT-1);
  assign w_wait  = mem_req_m_i && !mem_ready_i && !w_abort;
  assign w_lu    = result_src_e_i == 2'b01 && rd_e_i != '0 && (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);
  assign w_br    = pc_src_e_i;
  assign w_lu_stall = !w_wait && w_lu && !w_br;
  // every output is forced low combinationally while reset is asserted
  assign forward_a_e_o = rst_n ? fwd(rs1_e_i) : 2'b00;
  assign forward_b_e_o = rst_n ? fwd(rs2_e_i) : 2'b00;
  assign stall_f_o     = rst_n && (w_wait || w_lu_stall);
  assign stall_d_o     = rst_n && (w_wait || w_lu_stall);
  assign stall_e_o     = rst_n && w_wait;
  assign stall_m_o     = rst_n && w_wait;
  assign flush_d_o     = rst_n && !w_wait && w_br;
  assign flush_e_o     = rst_n && !w_wait && (w_br || w_lu);
  assign flush_w_o     = rst_n && (w_wait || w_abort);
  assign mem_timeout_o = rst_n && w_abort;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      stall_count_o <= '0;
    end else begin
      r_state       <= w_wait ? WAIT : IDLE;
      r_cnt         <= !w_wait ? '0 : (r_state == IDLE) ? TW'(1) : r_cnt + TW'(1);
      stall_count_o <= stall_count_o + CNT_WIDTH'(stall_f_o);
    end
  end
endmodule
